fifo_ctrl_sw_ar: RTL and testbench



---
 rtl/fifo_ctrl_sw_ar.sv | 82 ++++++++
 tb/tb_fifo_ctrl_sw_ar.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_sw_ar.sv
// rtl/fifo_ctrl_sw_ar.sv - FWFT FIFO controller for a sync-write / async-read 2-port memory
module fifo_ctrl_sw_ar #(
  parameter int W        = 8,
  parameter int D        = 128,
  parameter int AF_LEVEL = D - 2,
  localparam int DW      = $clog2(D),
  localparam int CW      = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          mem_we,
  output logic [DW-1:0] mem_waddr,
  output logic [W-1:0]  mem_wdata,
  output logic [DW-1:0] mem_raddr,
  input  logic [W-1:0]  mem_rdata
);

  localparam logic [CW-1:0] FULL_CNT = CW'(D);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [DW-1:0] LAST_PTR = DW'(D - 1);

  logic [DW-1:0] wptr;
  logic [DW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [DW-1:0] wptr_nxt;
  logic [DW-1:0] rptr_nxt;

  // Status and handshakes derive only from count, so neither ready nor valid
  // looks at the opposite side's handshake input.
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign almost_full = (count >= AF_CNT);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;

  // A write landing in the same cycle as a clear would leave no trace in
  // the pointers, but it is still suppressed so the memory sees no stray write.
  assign mem_we    = push & !rst & !flush;
  assign mem_waddr = wptr;
  assign mem_wdata = in_data;
  assign mem_raddr = rptr;
  assign out_data  = mem_rdata;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  assign wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + DW'(1);
  assign rptr_nxt = (rptr == LAST_PTR) ? '0 : rptr + DW'(1);

  // Pointer and occupancy state; rst beats flush, and both beat push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr_nxt;
      if (pop)  rptr <= rptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Occupancy can never exceed the depth.
  assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

endmodule

// File: tb/tb_fifo_ctrl_sw_ar.sv
// tb/tb_fifo_ctrl_sw_ar.sv - scoreboard bench for fifo_ctrl_sw_ar with D=4, AF_LEVEL=3
module tb_fifo_ctrl_sw_ar;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int DW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          mem_we;
  logic [DW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic [DW-1:0] mem_raddr;
  logic [W-1:0]  mem_rdata;

  logic [W-1:0]  mem [D];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q [$];

  fifo_ctrl_sw_ar #(.W(W), .D(D), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached memory: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare outputs against the
  // scoreboard, then advance the scoreboard as the rising edge will.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic rs);
    int sz;
    bit do_push;
    bit do_pop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    sz      = exp_q.size();
    do_push = iv && (sz < D) && !fl && !rs;
    do_pop  = ordy && (sz > 0) && !fl && !rs;
    check_eq("in_ready",    {31'd0, in_ready},    {31'd0, sz < D});
    check_eq("out_valid",   {31'd0, out_valid},   {31'd0, sz > 0});
    check_eq("count",       32'(count),           32'(sz));
    check_eq("almost_full", {31'd0, almost_full}, {31'd0, sz >= AF});
    check_eq("mem_we",      {31'd0, mem_we},      {31'd0, do_push});
    if (sz > 0) check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(id);
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset/idle state.
    cycle(0, 8'h00, 0, 0, 0);

    // Fill to full, then an extra offered word that must be refused.
    cycle(1, 8'hA1, 0, 0, 0);
    cycle(1, 8'hA2, 0, 0, 0);
    cycle(1, 8'hA3, 0, 0, 0);
    cycle(1, 8'hA4, 0, 0, 0);
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Drain in order, then idle empty.
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Simultaneous push/pop at count=2 across pointer wrap.
    cycle(1, 8'h10, 0, 0, 0);
    cycle(1, 8'h11, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h20 + i), 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Fall-through latency from empty.
    cycle(1, 8'h5C, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Flush with coincident push.
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0);
    cycle(1, 8'h77, 1, 1, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Reset together with flush and push.
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
    cycle(1, 8'h77, 1, 1, 1);
    cycle(0, 8'h00, 1, 0, 0);

    // Post-clear ordering still correct.
    cycle(1, 8'h88, 0, 0, 0);
    cycle(1, 8'h99, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
